// File: rtl/dcp_window_if.sv
// Pixel-stream input and 3-row column output of the dark-channel window sequencer.
// The slave modport is the sequencer. The master modport is the pixel source and column sink.
interface dcp_window_if;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_sof;
  logic        col_valid;
  logic [71:0] col_data;
  logic        col_sol;
  logic        col_eol;
  logic        frame_done;
  logic        sof_err;
  logic        busy;

  modport slave (
    input  s_valid, s_data, s_sof,
    output s_ready, col_valid, col_data, col_sol, col_eol, frame_done, sof_err, busy
  );

  modport master (
    output s_valid, s_data, s_sof,
    input  s_ready, col_valid, col_data, col_sol, col_eol, frame_done, sof_err, busy
  );
endinterface

// File: rtl/dcp_window_sequencer.sv
// Two-line-buffer raster sequencer that emits vertical 3-pixel columns for transmission estimation.
// Top and bottom border rows are replicated. The frame is closed by a one-row flush.
module dcp_window_sequencer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic         clk,
  input  logic         rst_n,
  dcp_window_if.slave  io
);
  // state  | meaning
  // IDLE   | waiting for s_sof; other pixels are accepted and dropped
  // FILL   | storing input row 0, no output
  // STREAM | input rows 1..IMG_H-1, one column per pixel for centre row y-1
  // FLUSH  | input stalled, emitting centre row IMG_H-1 from the line buffers
  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_t        state;
  logic [XW-1:0] x;
  logic [XW-1:0] fx;
  logic [YW-1:0] y;
  logic [23:0]   lb0 [IMG_W];
  logic [23:0]   lb1 [IMG_W];

  logic          xfer;
  logic [XW-1:0] wr_x;
  logic          x_last;

  assign io.s_ready = rst_n && (state != FLUSH);
  assign xfer       = io.s_valid && io.s_ready;
  // An SOF pixel is always written as column 0, whatever x currently holds.
  assign wr_x       = io.s_sof ? '0 : x;
  assign x_last     = (x == XW'(IMG_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      fx            <= '0;
      io.col_valid  <= 1'b0;
      io.col_data   <= '0;
      io.col_sol    <= 1'b0;
      io.col_eol    <= 1'b0;
      io.frame_done <= 1'b0;
      io.sof_err    <= 1'b0;
      io.busy       <= 1'b0;
    end else begin
      io.col_valid  <= 1'b0;
      io.col_sol    <= 1'b0;
      io.col_eol    <= 1'b0;
      io.frame_done <= 1'b0;
      io.sof_err    <= 1'b0;

      if (xfer && (state != IDLE || io.s_sof)) begin
        lb1[wr_x] <= lb0[wr_x];
        lb0[wr_x] <= io.s_data;
      end

      if (xfer && io.s_sof) begin
        // A new SOF restarts the frame from any accepting state. The old frame is dropped without a flush.
        io.sof_err <= (state != IDLE);
        x          <= XW'(1);
        y          <= '0;
        state      <= FILL;
        io.busy    <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          FILL: begin
            if (xfer) begin
              if (x_last) begin
                x     <= '0;
                y     <= YW'(1);
                state <= STREAM;
              end else begin
                x <= x + XW'(1);
              end
            end
          end
          STREAM: begin
            if (xfer) begin
              io.col_valid <= 1'b1;
              io.col_sol   <= (x == '0);
              io.col_eol   <= x_last;
              if (y == YW'(1))
                io.col_data <= {lb0[x], lb0[x], io.s_data};
              else
                io.col_data <= {lb1[x], lb0[x], io.s_data};
              if (x_last) begin
                x <= '0;
                if (y == YW'(IMG_H - 1)) begin
                  y     <= '0;
                  fx    <= '0;
                  state <= FLUSH;
                end else begin
                  y <= y + YW'(1);
                end
              end else begin
                x <= x + XW'(1);
              end
            end
          end
          FLUSH: begin
            io.col_valid <= 1'b1;
            io.col_sol   <= (fx == '0);
            io.col_eol   <= (fx == XW'(IMG_W - 1));
            io.col_data  <= {lb1[fx], lb0[fx], lb0[fx]};
            if (fx == XW'(IMG_W - 1)) begin
              fx            <= '0;
              io.frame_done <= 1'b1;
              io.busy       <= 1'b0;
              state         <= IDLE;
            end else begin
              fx <= fx + XW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dcp_window_sequencer.sv
// Scoreboard bench for dcp_window_sequencer at a 4x3 frame size.
// Expected columns are queued as pixels are driven and are popped as columns appear.
module tb_dcp_window_sequencer;
  localparam int W = 4;
  localparam int H = 3;

  typedef struct packed {
    logic [71:0] d;
    logic        sol;
    logic        eol;
    logic        fd;
  } col_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcp_window_if io ();

  dcp_window_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  col_t exp_q[$];
  col_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_cols = 0;
  int   n_eol = 0;
  int   n_ready_lo = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] px(input int y, input int x);
    return {8'(y), 8'(x), 8'h5A};
  endfunction

  function automatic col_t stream_col(input int y, input int x);
    col_t c;
    c.d   = {(y == 1) ? px(0, x) : px(y - 2, x), px(y - 1, x), px(y, x)};
    c.sol = (x == 0);
    c.eol = (x == W - 1);
    c.fd  = 1'b0;
    return c;
  endfunction

  function automatic col_t flush_col(input int x);
    col_t c;
    c.d   = {px(H - 2, x), px(H - 1, x), px(H - 1, x)};
    c.sol = (x == 0);
    c.eol = (x == W - 1);
    c.fd  = (x == W - 1);
    return c;
  endfunction

  always @(negedge clk) begin
    if (io.col_valid === 1'b1) begin
      n_cols++;
      if (io.col_eol === 1'b1) n_eol++;
      if (exp_q.size() == 0) begin
        check("col_unexpected", 72'(io.col_valid), 72'(0));
      end else begin
        e = exp_q.pop_front();
        check("col_data", io.col_data, e.d);
        check("col_flags", 72'({io.col_sol, io.col_eol, io.frame_done}), 72'({e.sol, e.eol, e.fd}));
      end
    end else if (mon_en && rst_n) begin
      check("idle_flags", 72'({io.col_sol, io.col_eol, io.frame_done}), 72'(0));
    end
    if (mon_en && rst_n && io.s_ready === 1'b0) n_ready_lo++;
  end

  task automatic send_px(input logic [23:0] d, input bit sof, input int gap,
                         input bit exp_err, input bit chk_first);
    int waited = 0;
    while (gap > 0 && $urandom_range(99) < gap) begin
      io.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    io.s_valid = 1'b1;
    io.s_data  = d;
    io.s_sof   = sof;
    while (io.s_ready !== 1'b1) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 200) begin
        $display("FAIL ready_timeout: s_ready low for %0d cycles, expected to rise", waited);
        $fatal(1);
      end
    end
    if (waited > 0 && sof) check("sof_after_done", 72'(io.frame_done), 72'(1));
    @(posedge clk); #1;
    check("sof_err", 72'(io.sof_err), 72'(exp_err));
    if (chk_first) begin
      check("first_col_valid", 72'(io.col_valid), 72'(1));
      check("first_col_sol", 72'(io.col_sol), 72'(1));
    end
    io.s_valid = 1'b0;
    io.s_sof   = 1'b0;
  endtask

  task automatic send_frame(input int gap, input bit abort_first, input int flush_n, input bit chk_first);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y >= 1) exp_q.push_back(stream_col(y, x));
        send_px(px(y, x), (y == 0 && x == 0), gap, abort_first && y == 0 && x == 0,
                chk_first && gap == 0 && y == 1 && x == 0);
      end
    end
    for (int fx = 0; fx < flush_n; fx++) exp_q.push_back(flush_col(fx));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk); #1;
    check("drain_q", 72'(exp_q.size()), 72'(0));
  endtask

  task automatic clr_counts();
    n_cols = 0;
    n_eol = 0;
    n_ready_lo = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    io.s_valid = 1'b0;
    io.s_sof   = 1'b0;
    io.s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 72'(io.s_ready), 72'(0));
    check("rst_col_valid", 72'(io.col_valid), 72'(0));
    check("rst_col_data", io.col_data, 72'(0));
    check("rst_flags", 72'({io.col_sol, io.col_eol, io.frame_done, io.sof_err, io.busy}), 72'(0));
    rst_n = 1'b1;
    #1;
    check("rel_s_ready", 72'(io.s_ready), 72'(1));
    mon_en = 1'b1;

    // full frame, no gaps
    clr_counts();
    send_frame(0, 1'b0, W, 1'b1);
    drain();
    check("full_cols", 72'(n_cols), 72'(W * H));
    check("full_eol", 72'(n_eol), 72'(H));
    check("full_ready_lo", 72'(n_ready_lo), 72'(W));
    check("full_busy", 72'(io.busy), 72'(0));

    // random valid gaps
    clr_counts();
    send_frame(50, 1'b0, W, 1'b0);
    drain();
    check("gap_cols", 72'(n_cols), 72'(W * H));
    check("gap_eol", 72'(n_eol), 72'(H));

    // stray pixels in IDLE, then a frame
    clr_counts();
    for (int i = 0; i < 5; i++) send_px(px(7, i), 1'b0, 0, 1'b0, 1'b0);
    check("stray_cols", 72'(n_cols), 72'(0));
    check("stray_busy", 72'(io.busy), 72'(0));
    send_frame(0, 1'b0, W, 1'b0);
    drain();
    check("stray_frame_cols", 72'(n_cols), 72'(W * H));

    // mid-frame SOF at (1,2) restarts the frame
    clr_counts();
    for (int i = 0; i < W + 2; i++) begin
      if (i >= W) exp_q.push_back(stream_col(1, i - W));
      send_px(px(i / W, i % W), (i == 0), 0, 1'b0, 1'b0);
    end
    send_frame(0, 1'b1, W, 1'b0);
    drain();
    check("abort_cols", 72'(n_cols), 72'(2 + W * H));

    // reset while FLUSH is at fx=1
    clr_counts();
    send_frame(0, 1'b0, 1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("frst_col_valid", 72'(io.col_valid), 72'(0));
    check("frst_flags", 72'({io.col_sol, io.col_eol, io.frame_done, io.sof_err, io.busy}), 72'(0));
    check("frst_col_data", io.col_data, 72'(0));
    check("frst_s_ready", 72'(io.s_ready), 72'(0));
    rst_n = 1'b1;
    #1;
    check("frst_rel_ready", 72'(io.s_ready), 72'(1));
    check("frst_q", 72'(exp_q.size()), 72'(0));
    clr_counts();
    send_frame(0, 1'b0, W, 1'b0);
    drain();
    check("frst_frame_cols", 72'(n_cols), 72'(W * H));

    // back-to-back frames; the second SOF waits out the flush
    clr_counts();
    send_frame(0, 1'b0, W, 1'b0);
    send_frame(0, 1'b0, W, 1'b0);
    drain();
    check("b2b_cols", 72'(n_cols), 72'(2 * W * H));
    check("b2b_eol", 72'(n_eol), 72'(2 * H));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
